data_bus_responder: RTL and testbench
=====================================

// Module: data_bus_responder
// PURPOSE
// Memory-mapped responder (target) for the processor data port. Answers the processor's
// ReadData/WriteData requests with DataDone after a fixed number of wait states.
// Backed by a local word RAM, plus two MMIO registers: halt (kill) and a free-running cycle counter.
// Sits between the processor data port and simulation/FPGA memory, in place of the generic data bus.
// PARAMETERS
// DEPTH        1024      RAM words; valid RAM addresses 0..DEPTH-1
// WAIT_STATES  2         extra cycles between request capture and DataDone (0..15)
// HALT_ADDR    16'hFFFF  write here -> Halted set (processor kill command)
// CYCLE_ADDR   16'hFFFE  read -> cycle counter; write -> counter cleared
// PORTS
// Clock      in   1   system clock, rising edge
// ResetN     in   1   asynchronous, active-low reset
// ReadData   in   1   read request from processor
// WriteData  in   1   write request from processor
// DataAddr   in   16  word address of request
// DataOut    in   16  processor write data
// DataIn     out  16  read data returned to processor
// DataDone   out  1   one-cycle completion pulse
// Halted     out  1   sticky; set by write to HALT_ADDR
// BusError   out  1   sticky; set on illegal request (see below)
// BEHAVIOUR
// - Reset (ResetN=0, async): state IDLE, DataIn=0, DataDone=0, Halted=0, BusError=0, counter=0,
//   wait counter=0. RAM contents are not cleared. Reset mid-transaction aborts it: no RAM write, no Done.
// - FSM: IDLE -> WAIT -> DONE -> IDLE.
//   IDLE: at an edge with (ReadData|WriteData)=1 and Halted=0, capture DataAddr, DataOut and op.
//     Go to WAIT if WAIT_STATES>0, else go to DONE.
//   WAIT: count WAIT_STATES edges, then go to DONE. Request inputs are ignored after capture.
//   DONE: DataDone=1 for exactly this cycle. On the next edge, return to IDLE.
// - Latency: with capture at edge t, DataDone is high in the cycle after edge t+WAIT_STATES.
//   WAIT_STATES=0 -> Done in the cycle after capture.
// - Writes commit on the edge that enters DONE:
//   RAM[addr], or Halted<=1 (HALT_ADDR), or counter<=0 (CYCLE_ADDR).
// - Reads: DataIn is loaded on the edge entering DONE and is valid while DataDone=1.
//   DataIn holds its value otherwise.
//   Sources: RAM[addr]; counter value as sampled at the capture edge (CYCLE_ADDR); 16'h0000 (HALT_ADDR).
// - Back-to-back: a request still high in the IDLE cycle after DONE is captured as a new transaction.
//   Minimum spacing between Done pulses is WAIT_STATES+2 cycles.
// - ReadData and WriteData both high at capture: executed as a write, BusError<=1.
// - Address >= DEPTH and not an MMIO address: still completes with DataDone.
//   Read returns 16'h0000, write is dropped, BusError<=1.
// - Halted=1: new requests are never captured (no DataDone).
//   A transaction already in flight completes normally. Only reset clears Halted and BusError.
// - Cycle counter: 16-bit, +1 every edge after reset, wraps FFFF->0000.
//   A CYCLE_ADDR write takes priority over the increment on that edge.
// - All arithmetic is unsigned, modulo 2^16. DataAddr bits above clog2(DEPTH) are decoded,
//   not truncated (no aliasing).
// TESTING
// 1 WAIT_STATES=2: write 16'h1234 @0x0010, then read 0x0010.
//   -> each Done exactly 3 cycles after capture; DataIn=16'h1234.
// 2 Read CYCLE_ADDR twice, 10 cycles apart (same WAIT_STATES).
//   -> returned values differ by 10. Write CYCLE_ADDR, then read -> value = WAIT_STATES+1.
// 3 Write 16'h0001 @HALT_ADDR -> Done pulses, Halted=1.
//   Next read @0x0000 -> no DataDone within 50 cycles.
// 4 Read 0x0400 with DEPTH=1024 -> Done, DataIn=0, BusError=1. RAM[0x0000] unchanged.
// 5 ReadData=WriteData=1, DataOut=16'hBEEF @0x0005 -> RAM[5]=16'hBEEF, BusError=1.
// 6 Assert ResetN=0 during WAIT of a write 16'hAAAA @0x0020 (RAM[0x20]=16'h5555 beforehand).
//   -> after release: DataDone=0, RAM[0x20]=16'h5555, counter restarts at 0.

Source files
------------

// File: rtl/data_bus_responder.sv
// data_bus_responder
//   Memory-mapped target for the processor data port. Each ReadData/WriteData
//   request is captured, held for WAIT_STATES cycles and then answered with a
//   one-cycle DataDone pulse. Requests are served by a local word RAM and by
//   two MMIO registers: a halt (kill) register and a free-running cycle counter.
//
// Ports
//   Clock      in   1   system clock, rising edge
//   ResetN     in   1   asynchronous active-low reset (RAM contents survive)
//   ReadData   in   1   read request
//   WriteData  in   1   write request (both high: treated as write + BusError)
//   DataAddr   in  16   word address
//   DataOut    in  16   write data from the processor
//   DataIn     out 16   read data, valid while DataDone=1, held otherwise
//   DataDone   out  1   one-cycle completion pulse
//   Halted     out  1   sticky, set by a write to HALT_ADDR
//   BusError   out  1   sticky, set by conflicting or unmapped requests

module data_bus_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] HALT_ADDR   = 16'hFFFF,
  parameter logic [15:0] CYCLE_ADDR  = 16'hFFFE
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        ReadData,
  input  logic        WriteData,
  input  logic [15:0] DataAddr,
  input  logic [15:0] DataOut,
  output logic [15:0] DataIn,
  output logic        DataDone,
  output logic        Halted,
  output logic        BusError
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic        conflict_q, conflict_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_cap_q, cnt_cap_d;
  logic [15:0] data_in_q, data_in_d;
  logic        done_q, done_d;
  logic        halted_q, halted_d;
  logic        buserr_q, buserr_d;

  logic [15:0] mem [DEPTH];

  logic          capture;
  logic          enter_done;
  logic [15:0]   txn_addr;
  logic [15:0]   txn_wdata;
  logic          txn_wr;
  logic          txn_conflict;
  logic [15:0]   txn_cnt;
  logic          hit_halt;
  logic          hit_cycle;
  logic          in_ram;
  logic [AW-1:0] ram_idx;
  logic [15:0]   ram_rdata;
  logic          ram_we;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    conflict_d = conflict_q;
    cnt_cap_d  = cnt_cap_q;
    data_in_d  = data_in_q;
    halted_d   = halted_q;
    buserr_d   = buserr_q;
    cnt_d      = cnt_q + 16'd1;
    done_d     = 1'b0;
    ram_we     = 1'b0;
    enter_done = 1'b0;

    capture = (state_q == S_IDLE) && (ReadData || WriteData) && !halted_q;

    // With WAIT_STATES=0 the capture edge is also the commit edge, so the
    // transaction fields come straight from the inputs on that edge and from
    // the captured registers otherwise.
    txn_addr     = capture ? DataAddr               : addr_q;
    txn_wdata    = capture ? DataOut                : wdata_q;
    txn_wr       = capture ? WriteData              : is_wr_q;
    txn_conflict = capture ? (ReadData && WriteData) : conflict_q;
    txn_cnt      = capture ? cnt_q                  : cnt_cap_q;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          addr_d     = DataAddr;
          wdata_d    = DataOut;
          is_wr_d    = WriteData;
          conflict_d = ReadData && WriteData;
          cnt_cap_d  = cnt_q;
          if (WAIT_STATES == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            wait_d  = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // MMIO addresses are matched on the full 16 bits before the RAM range.
    hit_halt  = (txn_addr == HALT_ADDR);
    hit_cycle = (txn_addr == CYCLE_ADDR);
    in_ram    = ({1'b0, txn_addr} < DEPTH_LIM);
    ram_idx   = txn_addr[AW-1:0];
    ram_rdata = mem[ram_idx];

    if (enter_done) begin
      done_d = 1'b1;
      if (txn_conflict) begin
        buserr_d = 1'b1;
      end
      if (txn_wr) begin
        if (hit_halt) begin
          halted_d = 1'b1;
        end else if (hit_cycle) begin
          cnt_d = '0;
        end else if (in_ram) begin
          ram_we = 1'b1;
        end else begin
          buserr_d = 1'b1;
        end
      end else begin
        if (hit_cycle) begin
          data_in_d = txn_cnt;
        end else if (hit_halt) begin
          data_in_d = '0;
        end else if (in_ram) begin
          data_in_d = ram_rdata;
        end else begin
          data_in_d = '0;
          buserr_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      cnt_cap_q  <= '0;
      data_in_q  <= '0;
      done_q     <= 1'b0;
      halted_q   <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      cnt_cap_q  <= cnt_cap_d;
      data_in_q  <= data_in_d;
      done_q     <= done_d;
      halted_q   <= halted_d;
      buserr_q   <= buserr_d;
    end
  end

  // RAM has no reset; an aborted transaction never reaches the commit edge.
  always_ff @(posedge Clock) begin
    if (ram_we) begin
      mem[ram_idx] <= txn_wdata;
    end
  end

  assign DataIn   = data_in_q;
  assign DataDone = done_q;
  assign Halted   = halted_q;
  assign BusError = buserr_q;

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned W     = 2;
  localparam logic [15:0] HALT  = 16'hFFFF;
  localparam logic [15:0] CYC   = 16'hFFFE;

  logic        Clock     = 1'b0;
  logic        ResetN    = 1'b0;
  logic        ReadData  = 1'b0;
  logic        WriteData = 1'b0;
  logic [15:0] DataAddr  = '0;
  logic [15:0] DataOut   = '0;
  logic [15:0] DataIn;
  logic        DataDone;
  logic        Halted;
  logic        BusError;

  data_bus_responder #(
    .DEPTH      (DEPTH),
    .WAIT_STATES(W),
    .HALT_ADDR  (HALT),
    .CYCLE_ADDR (CYC)
  ) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .ReadData (ReadData),
    .WriteData(WriteData),
    .DataAddr (DataAddr),
    .DataOut  (DataOut),
    .DataIn   (DataIn),
    .DataDone (DataDone),
    .Halted   (Halted),
    .BusError (BusError)
  );

  always #5 Clock = ~Clock;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic        run_cmp = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, timed by edge numbers.
  // A request seen at edge c completes on edge c+W; the bus is free again
  // from edge c+W+2 onward.
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_cnt  = '0;
  logic [15:0] m_din  = '0;
  logic        m_done = 1'b0;
  logic        m_halt = 1'b0;
  logic        m_berr = 1'b0;
  logic        m_busy = 1'b0;
  int unsigned m_edge = 0;
  int unsigned m_fin  = 0;
  logic        t_rd, t_wr;
  logic [15:0] t_addr, t_data, t_cnt;

  always @(posedge Clock or negedge ResetN) begin : model
    logic [15:0] pre;
    if (!ResetN) begin
      m_cnt  = '0;
      m_din  = '0;
      m_done = 1'b0;
      m_halt = 1'b0;
      m_berr = 1'b0;
      m_busy = 1'b0;
      m_edge = 0;
    end else begin
      m_edge++;
      m_done = 1'b0;
      pre    = m_cnt;
      m_cnt  = m_cnt + 16'd1;
      if (!m_busy && (ReadData || WriteData) && !m_halt) begin
        m_busy = 1'b1;
        m_fin  = m_edge + W;
        t_rd   = ReadData;
        t_wr   = WriteData;
        t_addr = DataAddr;
        t_data = DataOut;
        t_cnt  = pre;
      end
      if (m_busy && m_edge == m_fin) begin
        m_done = 1'b1;
        if (t_rd && t_wr) m_berr = 1'b1;
        if (t_wr) begin
          if (t_addr == HALT)        m_halt = 1'b1;
          else if (t_addr == CYC)    m_cnt  = '0;
          else if (t_addr < DEPTH)   m_mem[t_addr[9:0]] = t_data;
          else                       m_berr = 1'b1;
        end else begin
          if (t_addr == CYC)         m_din = t_cnt;
          else if (t_addr == HALT)   m_din = '0;
          else if (t_addr < DEPTH)   m_din = m_mem[t_addr[9:0]];
          else begin
            m_din  = '0;
            m_berr = 1'b1;
          end
        end
      end else if (m_busy && m_edge == m_fin + 1) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge Clock) begin
    if (run_cmp) begin
      chk("done",   {15'b0, DataDone}, {15'b0, m_done});
      chk("din",    DataIn,            m_din);
      chk("halted", {15'b0, Halted},   {15'b0, m_halt});
      chk("buserr", {15'b0, BusError}, {15'b0, m_berr});
    end
  end

  // Starts in an idle cycle, holds the request for one edge, then scrambles
  // the inputs (they must be ignored) and waits a bounded time for DataDone.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] data, output logic dn,
                     output logic [15:0] dv, output int lat);
    @(negedge Clock);
    ReadData  = rd;
    WriteData = wr;
    DataAddr  = addr;
    DataOut   = data;
    @(posedge Clock);
    #1;
    ReadData  = 1'b0;
    WriteData = 1'b0;
    DataAddr  = 16'($urandom);
    DataOut   = 16'($urandom);
    dn  = 1'b0;
    dv  = '0;
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clock);
      if (DataDone) begin
        dn  = 1'b1;
        dv  = DataIn;
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    #2 ResetN = 1'b0;
    @(negedge Clock);
    #2 ResetN = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end

  initial begin : stim
    logic        dn;
    logic [15:0] dv, c1, c2, v0, a, d;
    int          lat;
    int unsigned r, idx;
    logic        rd, wr;

    run_cmp = 1'b1;
    repeat (2) @(negedge Clock);
    chk("rst_din",    DataIn, 16'h0000);
    chk("rst_done",   {15'b0, DataDone}, 16'd0);
    chk("rst_berr",   {15'b0, BusError}, 16'd0);
    #2 ResetN = 1'b1;

    for (int i = 0; i <= 32; i++) begin
      a = (i == 32) ? 16'd1023 : 16'(i);
      txn(1'b0, 1'b1, a, 16'($urandom), dn, dv, lat);
    end

    // write then read back, latency W+1 sample points
    txn(1'b0, 1'b1, 16'h0010, 16'h1234, dn, dv, lat);
    chk("t1_wr_done", {15'b0, dn}, 16'd1);
    chk("t1_wr_lat",  16'(lat), 16'd3);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, dn, dv, lat);
    chk("t1_rd_lat",  16'(lat), 16'd3);
    chk("t1_rd_data", dv, 16'h1234);

    // counter reads 10 cycles apart
    txn(1'b1, 1'b0, CYC, 16'h0000, dn, dv, lat);
    c1 = dv;
    repeat (10 - (W + 2)) @(negedge Clock);
    txn(1'b1, 1'b0, CYC, 16'h0000, dn, dv, lat);
    c2 = dv;
    chk("t2_cnt_diff", c2 - c1, 16'd10);
    txn(1'b0, 1'b1, CYC, 16'h9999, dn, dv, lat);
    repeat (W) @(negedge Clock);
    txn(1'b1, 1'b0, CYC, 16'h0000, dn, dv, lat);
    chk("t2_cnt_clr", dv, 16'(W + 1));

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        idx = $urandom_range(0, 32);
        a   = (idx == 32) ? 16'd1023 : 16'(idx);
      end else if (r < 80) begin
        a = CYC;
      end else if (r < 85) begin
        a = HALT;
      end else begin
        a = 16'($urandom_range(1024, 65533));
      end
      r  = $urandom_range(0, 99);
      rd = (r < 45) || (r >= 95);
      wr = (r >= 45);
      if (a == HALT) begin
        rd = 1'b1;
        wr = 1'b0;
      end
      d = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge Clock);
      txn(rd, wr, a, d, dn, dv, lat);
      chk("rand_done", {15'b0, dn}, 16'd1);
    end

    // conflicting request: executed as write, flags error
    do_reset();
    chk("t5_berr0", {15'b0, BusError}, 16'd0);
    txn(1'b1, 1'b1, 16'h0005, 16'hBEEF, dn, dv, lat);
    chk("t5_berr1", {15'b0, BusError}, 16'd1);
    txn(1'b1, 1'b0, 16'h0005, 16'h0000, dn, dv, lat);
    chk("t5_data",  dv, 16'hBEEF);

    // unmapped read
    do_reset();
    chk("t4_berr0", {15'b0, BusError}, 16'd0);
    v0 = m_mem[0];
    txn(1'b1, 1'b0, 16'h0400, 16'h0000, dn, dv, lat);
    chk("t4_done",  {15'b0, dn}, 16'd1);
    chk("t4_data",  dv, 16'h0000);
    chk("t4_berr1", {15'b0, BusError}, 16'd1);
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, dn, dv, lat);
    chk("t4_ram0",  dv, v0);

    // halt
    txn(1'b0, 1'b1, 16'h0020, 16'h5555, dn, dv, lat);
    txn(1'b0, 1'b1, HALT, 16'h0001, dn, dv, lat);
    chk("t3_done",   {15'b0, dn}, 16'd1);
    chk("t3_halted", {15'b0, Halted}, 16'd1);
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, dn, dv, lat);
    chk("t3_no_done", {15'b0, dn}, 16'd0);

    // reset during the wait phase of a write
    do_reset();
    @(negedge Clock);
    WriteData = 1'b1;
    DataAddr  = 16'h0020;
    DataOut   = 16'hAAAA;
    @(posedge Clock);
    #1;
    WriteData = 1'b0;
    @(negedge Clock);
    #2 ResetN = 1'b0;
    @(negedge Clock);
    #2 ResetN = 1'b1;
    #1;
    chk("t6_done",   {15'b0, DataDone}, 16'd0);
    chk("t6_halted", {15'b0, Halted}, 16'd0);
    txn(1'b1, 1'b0, CYC, 16'h0000, dn, dv, lat);
    chk("t6_cnt",  dv, 16'd1);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, dn, dv, lat);
    chk("t6_ram",  dv, 16'h5555);

    repeat (3) @(negedge Clock);
    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
